// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD sequential converter.
//   state_t    : controller states (IDLE / SHIFT / DONE)
//   BIN_W_DEF  : default binary operand width
//   DIGITS_DEF : default number of BCD output digits
package bcd_pkg;

  localparam int unsigned BIN_W_DEF  = 8;
  localparam int unsigned DIGITS_DEF = 3;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/bcd_seq_ctrl_if.sv
// Request/result bundle of the binary-to-BCD converter.
//   start   : conversion request (master -> slave)
//   bin_in  : binary operand, captured when start is accepted (master -> slave)
//   busy    : conversion in progress (slave -> master)
//   done    : one-cycle pulse when bcd_out is updated (slave -> master)
//   bcd_out : packed BCD result, digit 0 in bits [3:0] (slave -> master)
interface bcd_seq_ctrl_if #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) ();

  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [DIGITS*4-1:0]   bcd_out;

  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  bcd_out
  );

  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output bcd_out
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble per-digit correction: add 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
//   din  : 4-bit digit before correction
//   dout : 4-bit digit after correction
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// A conversion takes BIN_W SHIFT cycles followed by a single DONE cycle in
// which the result is published on bcd_out and done pulses.
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bcd_seq_ctrl_if (start, bin_in, busy, done, bcd_out)
module bcd_seq_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = BIN_W_DEF,
  parameter int unsigned DIGITS = DIGITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_seq_ctrl_if.slave        bus
);

  localparam int unsigned BW = DIGITS * 4;
  localparam int unsigned CW = $clog2(BIN_W + 1);

  state_t            state, state_next;
  logic [BIN_W-1:0]  operand;
  logic [BW-1:0]     work;
  logic [BW-1:0]     adj;
  logic [BW-1:0]     work_shifted;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bcd_q;
  logic              accept;
  logic              last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (work[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  // Carry out of the top digit is dropped; it cannot occur when DIGITS is
  // wide enough for 2**BIN_W-1.
  assign work_shifted = BW'({adj, operand[BIN_W-1]});

  assign accept = bus.start && ((state == IDLE) || (state == DONE));
  assign last   = (state == SHIFT) && (cnt == CW'(BIN_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last)      state_next = DONE;
      DONE:    state_next = bus.start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand <= '0;
      work    <= '0;
      cnt     <= '0;
      bcd_q   <= '0;
    end else if (accept) begin
      operand <= bus.bin_in;
      work    <= '0;
      cnt     <= '0;
    end else if (state == SHIFT) begin
      operand <= operand << 1;
      work    <= work_shifted;
      cnt     <= cnt + CW'(1);
      // Publish the final shifted value on the same edge that enters DONE,
      // so bcd_out and done change together.
      if (last) begin
        bcd_q <= work_shifted;
      end
    end
  end

  assign bus.busy    = (state == SHIFT);
  assign bus.done    = (state == DONE);
  assign bus.bcd_out = bcd_q;

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Scoreboard bench for bcd_seq_ctrl: an acceptance observer pushes expected
// results, a monitor on the falling edge pops and compares them.
module tb_bcd_seq_ctrl;
  import bcd_pkg::*;

  localparam int unsigned BIN_W  = BIN_W_DEF;
  localparam int unsigned DIGITS = DIGITS_DEF;
  localparam int unsigned BW     = DIGITS * 4;

  logic clk = 1'b0;
  logic rst_n;

  bcd_seq_ctrl_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bcd_seq_ctrl #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned val;
    int          acc;
  } exp_t;

  exp_t          q[$];
  int            ecnt    = 0;
  int            next_ok = 0;
  logic [BW-1:0] exp_last = '0;
  int            checks   = 0;
  int            failures = 0;

  function automatic logic [BW-1:0] to_bcd(input int unsigned v);
    logic [BW-1:0] r;
    int unsigned   x;
    r = '0;
    x = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at edge %0d: actual=%0h required=%0h", name, ecnt, act, req);
    end
  endtask

  // Model of acceptance: a start is taken when no conversion is running,
  // and a conversion occupies BIN_W+1 edges before the next may start.
  always @(posedge clk) begin
    ecnt++;
    if (rst_n && bus.start && ecnt >= next_ok) begin
      q.push_back('{val: int'(bus.bin_in), acc: ecnt});
      next_ok = ecnt + int'(BIN_W) + 1;
    end
  end

  always @(negedge clk) begin
    logic exp_busy, exp_done;
    if (!rst_n) begin
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_bcd",  64'(bus.bcd_out), 64'd0);
    end else begin
      exp_busy = (q.size() > 0) && (ecnt >= q[0].acc) && (ecnt < q[0].acc + int'(BIN_W));
      exp_done = (q.size() > 0) && (ecnt == q[0].acc + int'(BIN_W));
      chk("busy", 64'(bus.busy), 64'(exp_busy));
      chk("done", 64'(bus.done), 64'(exp_done));
      if (exp_done) begin
        exp_last = to_bcd(q[0].val);
        chk("bcd_out", 64'(bus.bcd_out), 64'(exp_last));
        void'(q.pop_front());
      end else begin
        chk("bcd_hold", 64'(bus.bcd_out), 64'(exp_last));
      end
    end
  end

  task automatic flush_model();
    q.delete();
    next_ok  = 0;
    exp_last = '0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && q.size() != 0; i++) begin
      @(posedge clk) #1;
    end
    chk("idle_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic conv(input int unsigned v);
    bus.start  = 1'b1;
    bus.bin_in = BIN_W'(v);
    @(posedge clk) #1;
    bus.start  = 1'b0;
    wait_idle();
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    flush_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // First start right after release, then directed values.
    conv(0);
    conv(99);
    conv(255);
    conv(100);

    // Operand change and extra start while shifting.
    bus.start  = 1'b1;
    bus.bin_in = 8'd47;
    @(posedge clk) #1;
    bus.start  = 1'b0;
    bus.bin_in = 8'd200;
    repeat (2) @(posedge clk) #1;
    bus.start  = 1'b1;
    @(posedge clk) #1;
    bus.start  = 1'b0;
    wait_idle();

    // Reset in the middle of a conversion.
    bus.start  = 1'b1;
    bus.bin_in = 8'd123;
    @(posedge clk) #1;
    bus.start  = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    flush_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    conv(64);

    // Back-to-back sweep with start held high; operand scrambled after capture.
    bus.start = 1'b1;
    for (int unsigned v = 0; v < (1 << BIN_W); v++) begin
      bus.bin_in = BIN_W'(v);
      @(posedge clk) #1;
      repeat (BIN_W) begin
        bus.bin_in = BIN_W'($urandom);
        @(posedge clk) #1;
      end
    end
    bus.start = 1'b0;
    wait_idle();

    // Random start pulses at arbitrary phases.
    for (int i = 0; i < 400; i++) begin
      bus.start  = ($urandom_range(0, 3) == 0);
      bus.bin_in = BIN_W'($urandom);
      @(posedge clk) #1;
    end
    bus.start = 1'b0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_seq_ctrl.md
BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

Interface
REQ-001 SHALL have parameter BIN_W, default 8, binary input width.
REQ-002 SHALL have parameter DIGITS, default 3, number of BCD digits; DIGITS*4 >= enough to hold 2**BIN_W-1.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  conversion request, sampled on rising clk.
REQ-006 SHALL have port bin_in  input  BIN_W  binary operand, captured when start is accepted.
REQ-007 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse when bcd_out is updated.
REQ-009 SHALL have port bcd_out  output  DIGITS*4  packed BCD result, digit 0 in bits [3:0].

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-011 SHALL accept start only in IDLE or DONE; accept = capture bin_in into an operand register, clear a working BCD register to 0, clear iteration counter, go to SHIFT.
REQ-012 SHALL ignore start while in SHIFT; operand and bcd_out unaffected.
REQ-013 SHALL in each SHIFT cycle: for every digit of the working register, add 3 if digit >= 5; then shift the working register left by 1, shifting in the operand MSB; shift the operand left by 1.
REQ-014 SHALL perform exactly BIN_W SHIFT cycles, counted by a counter of width clog2(BIN_W+1); after the last one go to DONE.
REQ-015 SHALL on entry to DONE load bcd_out from the working register and assert done for exactly that one cycle.
REQ-016 SHALL return from DONE to IDLE the next cycle unless start is high, in which case a new conversion begins (back-to-back, no idle gap).
REQ-017 SHALL assert busy in SHIFT only; busy low in IDLE and DONE.
REQ-018 Latency: start accepted on edge N -> done high during cycle N+BIN_W+1; busy high cycles N+1..N+BIN_W.
REQ-019 SHALL hold bcd_out stable between done pulses; working register never drives bcd_out directly.
REQ-020 SHALL convert every value 0..2**BIN_W-1 exactly; digit carries are discarded only beyond DIGITS digits (cannot occur when REQ-002 holds).
REQ-021 bin_in changes after acceptance SHALL NOT affect the running conversion.

Reset
REQ-022 SHALL on rst_n low, asynchronously: state=IDLE, busy=0, done=0, bcd_out=0, operand, working register and counter = 0.
REQ-023 Reset asserted mid-conversion SHALL abort it; no done pulse; bcd_out reads 0 after release.
REQ-024 First start SHALL be accepted on the first rising clk after rst_n deasserts.

Structure
REQ-025 Package bcd_pkg SHALL hold the state enum (IDLE/SHIFT/DONE) and default constants BIN_W_DEF=8, DIGITS_DEF=3.
REQ-026 Per-digit add-3 correction SHALL be a sub-module bcd_digit_adj (4-bit in, 4-bit out, combinational), instantiated DIGITS times by generate.
REQ-027 Controller FSM, counter and shift registers SHALL reside in bcd_seq_ctrl.

Verification
REQ-028 Reset, then start with bin_in=8'd0 -> done at cycle 9, bcd_out=12'h000, busy high exactly 8 cycles.
REQ-029 start with bin_in=8'd99 -> bcd_out=12'h099; bin_in=8'd255 -> 12'h255; bin_in=8'd100 -> 12'h100.
REQ-030 start held high continuously, bin_in stepping 0..255 -> one done every 9 cycles, each bcd_out matching decimal of its captured operand; start pulses during SHIFT ignored.
REQ-031 start bin_in=8'd47, change bin_in to 8'd200 during SHIFT -> bcd_out=12'h047.
REQ-032 start bin_in=8'd123, assert rst_n low at cycle 4 -> no done, bcd_out=0, busy=0; after release, new start with 8'd64 -> 12'h064.
REQ-033 Exhaustive sweep 0..255 against reference model; any mismatch fails.
